qam_mod_param: RTL and testbench

QAM_MOD_PARAM -- requirements
Module: qam_mod_param

---
 rtl/qam_pkg.sv | 39 +++
 rtl/qam_mod_param_if.sv | 24 ++
 rtl/qam_level_map.sv | 24 ++
 rtl/qam_mod_param.sv | 124 ++++++++++++
 tb/tb_qam_mod_param.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/qam_pkg.sv
// Shared mode encoding and helpers for the parameterised QAM mapper.
package qam_pkg;

    typedef enum logic [2:0] {
        MODE_BPSK   = 3'd0,
        MODE_QPSK   = 3'd1,
        MODE_QAM16  = 3'd2,
        MODE_QAM64  = 3'd3,
        MODE_QAM256 = 3'd4
    } mode_e;

    function automatic logic mode_ok(input logic [2:0] mode);
        return mode <= 3'(MODE_QAM256);
    endfunction

    // Invalid modes report zero bits so they can never emit a symbol
    function automatic logic [3:0] bits_per_sym(input logic [2:0] mode);
        logic [3:0] b;
        case (mode)
            MODE_BPSK:   b = 4'd1;
            MODE_QPSK:   b = 4'd2;
            MODE_QAM16:  b = 4'd4;
            MODE_QAM64:  b = 4'd6;
            MODE_QAM256: b = 4'd8;
            default:     b = 4'd0;
        endcase
        return b;
    endfunction

    function automatic logic [3:0] gray2bin(input logic [3:0] g);
        logic [3:0] n;
        n[3] = g[3];
        for (int i = 2; i >= 0; i--) begin
            n[i] = n[i+1] ^ g[i];
        end
        return n;
    endfunction

endpackage

// File: rtl/qam_mod_param_if.sv
// Word-in / symbol-out stream bundle of the QAM mapper.
interface qam_mod_param_if #(
    parameter int DATA_W   = 32,
    parameter int SAMPLE_W = 16
);
    logic [DATA_W-1:0]     signal_in;
    logic                  valid_in;
    logic                  ready_out;
    logic [2:0]            qam;
    logic [2*SAMPLE_W-1:0] signal_out;
    logic                  valid_out;
    logic                  ready_in;
    logic                  error;

    modport slave (
        input  signal_in, valid_in, qam, ready_in,
        output ready_out, signal_out, valid_out, error
    );

    modport master (
        output signal_in, valid_in, qam, ready_in,
        input  ready_out, signal_out, valid_out, error
    );
endinterface

// File: rtl/qam_level_map.sv
// Gray index to scaled two's-complement amplitude; h=0 yields zero.
module qam_level_map import qam_pkg::*; #(
    parameter int SAMPLE_W = 16,
    parameter int SCALE    = 12
) (
    input  logic [3:0]          idx,
    input  logic [2:0]          h,
    output logic [SAMPLE_W-1:0] sample
);
    logic [3:0]                 n;
    logic [5:0]                 level;
    logic signed [SAMPLE_W-1:0] ext;

    always_comb begin
        n     = gray2bin(idx);
        level = {1'b0, n, 1'b1} - (6'd1 << h);
        ext   = SAMPLE_W'($signed(level));
        if (h == 3'd0) begin
            sample = '0;
        end else begin
            sample = ext <<< SCALE;
        end
    end
endmodule

// File: rtl/qam_mod_param.sv
// Bit-buffered BPSK..256-QAM mapper: DATA_W words in, {I,Q} symbols out.
module qam_mod_param import qam_pkg::*; #(
    parameter int DATA_W   = 32,
    parameter int SAMPLE_W = 16,
    parameter int SCALE    = 12
) (
    input  logic           clk,
    input  logic           rst,
    qam_mod_param_if.slave bus
);
    localparam int BW = DATA_W + 7;
    localparam int CW = $clog2(BW + 1);

    logic [BW-1:0]         bits_r;
    logic [CW-1:0]         cnt_r;
    logic [2:0]            mode_r;
    logic [2*SAMPLE_W-1:0] out_r;
    logic                  vld_r;
    logic                  err_r;

    logic [BW-1:0]         bits_eff;
    logic [BW-1:0]         comb;
    logic [CW-1:0]         cnt_eff;
    logic [CW-1:0]         cnt_comb;
    logic [2:0]            mode_eff;
    logic [3:0]            b_r;
    logic [3:0]            b_eff;
    logic [CW-1:0]         br_w;
    logic [CW-1:0]         be_w;
    logic                  out_free;
    logic                  latch;
    logic                  ready;
    logic                  accept;
    logic                  emit;
    logic [7:0]            sym;
    logic [2:0]            h_i;
    logic [2:0]            h_q;
    logic [3:0]            idx_i;
    logic [3:0]            idx_q;
    logic [SAMPLE_W-1:0]   smp_i;
    logic [SAMPLE_W-1:0]   smp_q;

    always_comb begin
        out_free = !vld_r || bus.ready_in;
        b_r      = bits_per_sym(mode_r);
        br_w     = CW'(b_r);
        latch    = out_free && (cnt_r < br_w || cnt_r == '0);
        mode_eff = latch ? bus.qam : mode_r;
        b_eff    = bits_per_sym(mode_eff);
        be_w     = CW'(b_eff);
        bits_eff = bits_r;
        cnt_eff  = cnt_r;
        // A newly latched mode cannot reuse residual bits of the old one
        if (latch && mode_eff != mode_r) begin
            bits_eff = '0;
            cnt_eff  = '0;
        end
        ready    = rst && mode_ok(mode_eff) && cnt_eff < be_w;
        accept   = ready && bus.valid_in;
        comb     = bits_eff;
        cnt_comb = cnt_eff;
        if (accept) begin
            comb     = bits_eff | ({bus.signal_in, 7'b0} >> cnt_eff);
            cnt_comb = cnt_eff + CW'(DATA_W);
        end
        emit  = out_free && b_eff != 4'd0 && cnt_comb >= be_w;
        sym   = comb[BW-1 -: 8];
        h_q   = b_eff[3:1];
        h_i   = (b_eff == 4'd1) ? 3'd1 : b_eff[3:1];
        idx_i = 4'(sym >> (8 - int'(h_i)));
        idx_q = 4'(sym >> (8 - 2 * int'(h_q)))
              & ((4'd1 << h_q) - 4'd1);
    end

    qam_level_map #(
        .SAMPLE_W (SAMPLE_W),
        .SCALE    (SCALE)
    ) u_map_i (
        .idx    (idx_i),
        .h      (h_i),
        .sample (smp_i)
    );

    qam_level_map #(
        .SAMPLE_W (SAMPLE_W),
        .SCALE    (SCALE)
    ) u_map_q (
        .idx    (idx_q),
        .h      (h_q),
        .sample (smp_q)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            bits_r <= '0;
            cnt_r  <= '0;
            mode_r <= '0;
            out_r  <= '0;
            vld_r  <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            if (latch) begin
                mode_r <= bus.qam;
            end
            err_r <= !mode_ok(mode_eff);
            if (emit) begin
                bits_r <= comb << b_eff;
                cnt_r  <= cnt_comb - be_w;
                out_r  <= {smp_i, smp_q};
                vld_r  <= 1'b1;
            end else begin
                bits_r <= comb;
                cnt_r  <= cnt_comb;
                vld_r  <= vld_r && !bus.ready_in;
            end
        end
    end

    assign bus.ready_out  = ready;
    assign bus.signal_out = out_r;
    assign bus.valid_out  = vld_r;
    assign bus.error      = err_r;

endmodule

// File: tb/tb_qam_mod_param.sv
// Bench for qam_mod_param: directed cases plus random bursts vs a bit-queue model.
module tb_qam_mod_param;

    logic clk = 1'b0;
    logic rst;

    qam_mod_param_if #(.DATA_W(32), .SAMPLE_W(16)) bus ();

    qam_mod_param #(
        .DATA_W   (32),
        .SAMPLE_W (16),
        .SCALE    (12)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cur_mode = 1;
    int          bp = 0;
    int          sym_cnt = 0;
    bit          bitq[$];
    logic [31:0] sym_log[$];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int bps(int m);
        case (m)
            0: return 1;
            1: return 2;
            2: return 4;
            3: return 6;
            4: return 8;
            default: return 0;
        endcase
    endfunction

    function automatic int lvl(int g, int h);
        int n = 0;
        for (int k = g; k != 0; k = k >> 1) n = n ^ k;
        return 2 * n + 1 - (1 << h);
    endfunction

    function automatic logic [31:0] ref_sym(int m, int v);
        int b, h, i, q;
        logic [15:0] si, sq;
        b = bps(m);
        h = b / 2;
        if (b == 1) begin
            i = (v != 0) ? 1 : -1;
            q = 0;
        end else begin
            i = lvl(v >> h, h);
            q = lvl(v & ((1 << h) - 1), h);
        end
        si = 16'(i * 4096);
        sq = 16'(q * 4096);
        return {si, sq};
    endfunction

    always @(posedge clk) begin
        #1;
        case (bp)
            0: bus.ready_in = 1'b1;
            1: bus.ready_in = ($urandom_range(0, 3) != 0);
            default: bus.ready_in = 1'b0;
        endcase
    end

    // Scoreboard: accepted words feed a bit queue, handshaked symbols drain it
    always @(negedge clk) begin : mon
        bit          stall_prev;
        logic [31:0] held;
        int          b;
        int          v;
        if (rst !== 1'b1) begin
            bitq.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_vld", bus.valid_out, 1);
                check("hold_data", bus.signal_out, held);
            end
            if (bus.valid_out && bus.ready_in) begin
                b = bps(cur_mode);
                check("sym_mode_ok", b != 0, 1);
                check("sym_bits_avail", bitq.size() >= b, 1);
                v = 0;
                for (int k = 0; k < b; k++) begin
                    if (bitq.size() > 0) v = (v << 1) | int'(bitq.pop_front());
                end
                check("sym", bus.signal_out, ref_sym(cur_mode, v));
                sym_log.push_back(bus.signal_out);
                sym_cnt++;
            end
            if (bus.valid_in && bus.ready_out) begin
                for (int k = 31; k >= 0; k--) bitq.push_back(bus.signal_in[k]);
            end
            stall_prev = bus.valid_out && !bus.ready_in;
            held = bus.signal_out;
        end
    end

    task automatic set_mode(input int m);
        if (m != cur_mode) bitq.delete();
        cur_mode = m;
        bus.qam = 3'(m);
    endtask

    task automatic send_word(input logic [31:0] w);
        bit ok = 1'b0;
        bus.signal_in = w;
        bus.valid_in = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = bus.ready_out;
            @(posedge clk);
            #1;
        end
        check("accept_timeout", ok, 1);
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            done = !bus.valid_out && bitq.size() < bps(cur_mode);
        end
        @(posedge clk);
        #1;
        check("drain_timeout", done, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          base;
        int          q0;
        int          n;
        int          m;
        logic [31:0] w1, w2, w3, w4, s0;

        rst = 1'b0;
        bus.valid_in = 1'b1;
        bus.qam = 3'd1;
        bus.signal_in = 32'hEAAAAAAA;
        repeat (2) begin
            @(negedge clk);
            check("rst_sig", bus.signal_out, 0);
            check("rst_vld", bus.valid_out, 0);
            check("rst_rdy", bus.ready_out, 0);
            check("rst_err", bus.error, 0);
        end

        // QPSK: accept on the first cycle out of reset, symbols next cycle
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("qpsk_acc", bus.ready_out, 1);
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check("qpsk_vld", bus.valid_out, 1);
            check("qpsk_sym", bus.signal_out,
                  (k == 1) ? 32'h1000_1000 : 32'h1000_F000);
            check("qpsk_rdy", bus.ready_out, k == 16);
        end
        @(negedge clk);
        check("qpsk_end", bus.valid_out, 0);

        // 16-QAM fixed pattern
        @(posedge clk);
        #1;
        set_mode(2);
        bus.signal_in = 32'hE0000000;
        bus.valid_in = 1'b1;
        @(negedge clk);
        check("q16_acc", bus.ready_out, 1);
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("q16_sym", bus.signal_out,
                  (k == 0) ? 32'h1000_3000 : 32'hD000_D000);
        end
        drain();

        // 64-QAM carry across three words
        set_mode(3);
        base = sym_cnt;
        w1 = $urandom;
        w2 = $urandom;
        w3 = $urandom;
        send_word(w1);
        send_word(w2);
        send_word(w3);
        bus.valid_in = 1'b0;
        drain();
        check("q64_cnt", sym_cnt - base, 16);
        check("q64_sym6", sym_log[base+5], ref_sym(3, int'({w1[1:0], w2[31:28]})));
        w4 = $urandom;
        send_word(w4);
        bus.valid_in = 1'b0;
        drain();
        check("q64_nores", sym_log[base+16], ref_sym(3, int'(w4[31:26])));

        // Backpressure stall mid-stream in 256-QAM
        set_mode(4);
        base = sym_cnt;
        send_word($urandom);
        bus.valid_in = 1'b0;
        bp = 2;
        @(negedge clk);
        @(negedge clk);
        s0 = bus.signal_out;
        repeat (5) @(negedge clk);
        check("bp_hold", bus.signal_out, s0);
        check("bp_vld", bus.valid_out, 1);
        bp = 0;
        @(posedge clk);
        #1;
        send_word($urandom);
        bus.valid_in = 1'b0;
        drain();
        check("bp_cnt", sym_cnt - base, 8);

        // Invalid mode, then recovery
        set_mode(5);
        bus.signal_in = $urandom;
        bus.valid_in = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("err_set", bus.error, 1);
        check("err_rdy", bus.ready_out, 0);
        repeat (3) begin
            @(negedge clk);
            check("err_hold_rdy", bus.ready_out, 0);
            check("err_no_sym", bus.valid_out, 0);
        end
        @(posedge clk);
        #1;
        base = sym_cnt;
        set_mode(2);
        @(negedge clk);
        check("err_resume_rdy", bus.ready_out, 1);
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
        @(negedge clk);
        check("err_clr", bus.error, 0);
        drain();
        check("err_resume_cnt", sym_cnt - base, 8);

        // Random bursts with random backpressure and mode switches
        bp = 1;
        for (int it = 0; it < 30; it++) begin
            m = $urandom_range(0, 4);
            set_mode(m);
            q0 = bitq.size();
            base = sym_cnt;
            n = $urandom_range(1, 3);
            repeat (n) send_word($urandom);
            bus.valid_in = 1'b0;
            drain();
            check("rand_cnt", sym_cnt - base, (q0 + 32 * n) / bps(m));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
